// File: rtl/pwm_multi_pkg.sv
// rtl/pwm_multi_pkg.sv - register map, CTRL bit positions and parameter range checks for pwm_multi
package pwm_multi_pkg;

    localparam int ADR_CTRL   = 0;
    localparam int ADR_PERIOD = 1;
    localparam int ADR_CH_EN  = 2;
    localparam int ADR_POL    = 3;
    localparam int ADR_DUTY0  = 4;

    localparam int CTRL_GEN = 0;
    localparam int CTRL_UPD = 1;

    localparam int NUM_CH_MIN = 1;
    localparam int NUM_CH_MAX = 16;
    localparam int CNT_W_MIN  = 2;
    localparam int CNT_W_MAX  = 32;

    function automatic bit params_ok(int num_ch, int cnt_w, int addr_w);
        return (num_ch >= NUM_CH_MIN) && (num_ch <= NUM_CH_MAX) &&
               (cnt_w >= CNT_W_MIN) && (cnt_w <= CNT_W_MAX) &&
               ((2 ** addr_w) >= (ADR_DUTY0 + num_ch));
    endfunction

endpackage

// File: rtl/pwm_multi_channel.sv
// rtl/pwm_multi_channel.sv - one PWM channel: shadow/active duty pair, compare and output register
module pwm_channel
    import pwm_multi_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr,
    input  logic [CNT_W-1:0] wdata,
    input  logic             load,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] period_act,
    input  logic             enable,
    input  logic             polarity,
    output logic [CNT_W-1:0] duty_sh,
    output logic             pwm
);

    logic [CNT_W-1:0] duty_act;
    logic             raw;

    // Duty >= period never satisfies the compare's false side, giving a full-high period.
    assign raw = enable && (period_act != '0) && (cnt < duty_act);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            duty_sh  <= '0;
            duty_act <= '0;
            pwm      <= 1'b0;
        end else begin
            if (wr) begin
                duty_sh <= wdata;
            end
            if (load) begin
                duty_act <= duty_sh;
            end
            pwm <= raw ^ polarity;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM generator with shared counter and boundary-synchronised updates
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 20,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_n,
    input  logic              rd_n,
    input  logic [31:0]       i_data,
    output logic [31:0]       o_data,
    output logic [NUM_CH-1:0] o_pwm,
    output logic              o_wrap
);

    if (!params_ok(NUM_CH, CNT_W, ADDR_W)) begin : g_bad_params
        $error("pwm_multi: NUM_CH, CNT_W or ADDR_W out of range");
    end

    logic              gen;
    logic              upd_pend;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] pol;
    logic [CNT_W-1:0]  period_sh;
    logic [CNT_W-1:0]  period_act;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  duty_sh [NUM_CH];
    logic [NUM_CH-1:0] duty_wr;
    logic              wr_ctrl, wr_period, wr_ch_en, wr_pol;
    logic              running, at_end, load;
    logic [31:0]       rd_mux;
    logic              unused_data;

    assign unused_data = ^i_data;

    assign wr_ctrl   = !wr_n && (addr == ADDR_W'(ADR_CTRL));
    assign wr_period = !wr_n && (addr == ADDR_W'(ADR_PERIOD));
    assign wr_ch_en  = !wr_n && (addr == ADDR_W'(ADR_CH_EN));
    assign wr_pol    = !wr_n && (addr == ADDR_W'(ADR_POL));

    // Idle or zero-period states transfer every cycle so a stuck P=0 can be escaped.
    assign running = gen && (period_act != '0);
    assign at_end  = running && (cnt == period_act - 1'b1);
    assign load    = !running || at_end;

    always_comb begin
        rd_mux = '0;
        case (addr)
            ADDR_W'(ADR_CTRL): begin
                rd_mux[CTRL_GEN] = gen;
                rd_mux[CTRL_UPD] = upd_pend;
            end
            ADDR_W'(ADR_PERIOD): rd_mux[CNT_W-1:0]  = period_sh;
            ADDR_W'(ADR_CH_EN):  rd_mux[NUM_CH-1:0] = ch_en;
            ADDR_W'(ADR_POL):    rd_mux[NUM_CH-1:0] = pol;
            default: ;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr == ADDR_W'(ADR_DUTY0 + i)) begin
                rd_mux[CNT_W-1:0] = duty_sh[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gen        <= 1'b0;
            upd_pend   <= 1'b0;
            ch_en      <= '0;
            pol        <= '0;
            period_sh  <= '0;
            period_act <= '0;
            cnt        <= '0;
            o_wrap     <= 1'b0;
            o_data     <= '0;
        end else begin
            if (wr_ctrl) begin
                gen <= i_data[CTRL_GEN];
            end
            if (wr_period) begin
                period_sh <= i_data[CNT_W-1:0];
            end
            if (wr_ch_en) begin
                ch_en <= i_data[NUM_CH-1:0];
            end
            if (wr_pol) begin
                pol <= i_data[NUM_CH-1:0];
            end
            if (load) begin
                period_act <= period_sh;
            end
            // A write coinciding with a transfer keeps the flag set for the next boundary.
            if (wr_period || (|duty_wr)) begin
                upd_pend <= 1'b1;
            end else if (load) begin
                upd_pend <= 1'b0;
            end
            cnt    <= (running && !at_end) ? cnt + 1'b1 : '0;
            o_wrap <= at_end;
            if (!rd_n) begin
                o_data <= rd_mux;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign duty_wr[i] = !wr_n && (addr == ADDR_W'(ADR_DUTY0 + i));

        pwm_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .wr        (duty_wr[i]),
            .wdata     (i_data[CNT_W-1:0]),
            .load      (load),
            .cnt       (cnt),
            .period_act(period_act),
            .enable    (gen & ch_en[i]),
            .polarity  (pol[i]),
            .duty_sh   (duty_sh[i]),
            .pwm       (o_pwm[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - self-checking bench for pwm_multi
module tb_pwm_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 20;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic              wr_n = 1'b1;
    logic              rd_n = 1'b1;
    logic [31:0]       i_data = '0;
    logic [31:0]       o_data;
    logic [NUM_CH-1:0] o_pwm;
    logic              o_wrap;

    pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .wr_n(wr_n), .rd_n(rd_n),
        .i_data(i_data), .o_data(o_data), .o_pwm(o_pwm), .o_wrap(o_wrap)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: registers as the CPU sees them plus the period position.
    bit                m_gen, m_pend;
    logic [CNT_W-1:0]  m_psh, m_pact, m_cnt;
    logic [CNT_W-1:0]  m_dsh [NUM_CH];
    logic [CNT_W-1:0]  m_dact [NUM_CH];
    logic [NUM_CH-1:0] m_en, m_pol;

    int cnt_hi [NUM_CH];
    int cnt_wrap;

    typedef struct {
        int          waddr;
        logic [31:0] wdata;
        int          raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gen = 0; m_pend = 0; m_psh = '0; m_pact = '0; m_cnt = '0;
        m_en = '0; m_pol = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_dsh[i] = '0;
            m_dact[i] = '0;
        end
    endtask

    task automatic model_write(input int a, input logic [31:0] d);
        if (a == 0) m_gen = d[0];
        else if (a == 1) begin m_psh = d[CNT_W-1:0]; m_pend = 1; end
        else if (a == 2) m_en = d[NUM_CH-1:0];
        else if (a == 3) m_pol = d[NUM_CH-1:0];
        else if (a >= 4 && a < 4 + NUM_CH) begin m_dsh[a-4] = d[CNT_W-1:0]; m_pend = 1; end
    endtask

    function automatic logic [31:0] model_read(input int a);
        if (a == 0) return {30'b0, m_pend, m_gen};
        if (a == 1) return 32'(m_psh);
        if (a == 2) return 32'(m_en);
        if (a == 3) return 32'(m_pol);
        if (a >= 4 && a < 4 + NUM_CH) return 32'(m_dsh[a-4]);
        return 32'h0;
    endfunction

    // One clock: predict outputs from the pre-edge state, compare, then advance the model.
    task automatic tick();
        logic              run, last;
        logic [NUM_CH-1:0] e_pwm;
        run  = m_gen && (m_pact != '0);
        last = run && (m_cnt == m_pact - 1);
        for (int i = 0; i < NUM_CH; i++)
            e_pwm[i] = m_pol[i] ^ (run && m_en[i] && (m_cnt < m_dact[i]));
        @(negedge clk);
        check("o_pwm", 32'(o_pwm), 32'(e_pwm));
        check("o_wrap", 32'(o_wrap), 32'(last));
        m_cnt = (run && !last) ? m_cnt + 1 : '0;
        if (!run || last) begin
            m_pact = m_psh;
            for (int i = 0; i < NUM_CH; i++) m_dact[i] = m_dsh[i];
            m_pend = 0;
        end
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        addr = ADDR_W'(a); i_data = d; wr_n = 1'b0;
        tick();
        wr_n = 1'b1;
        model_write(a, d);
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        addr = ADDR_W'(a); rd_n = 1'b0;
        tick();
        rd_n = 1'b1;
        d = o_data;
    endtask

    task automatic rd_chk(input string name, input int a);
        logic [31:0] exp, got;
        exp = model_read(a);
        rd(a, got);
        check(name, got, exp);
    endtask

    task automatic run_count(input int n);
        cnt_wrap = 0;
        for (int i = 0; i < NUM_CH; i++) cnt_hi[i] = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            for (int i = 0; i < NUM_CH; i++) cnt_hi[i] += int'(o_pwm[i]);
            cnt_wrap += int'(o_wrap);
        end
    endtask

    task automatic wait_cnt(input int c);
        int k = 0;
        while (m_cnt != CNT_W'(c) && k < 64) begin
            tick();
            k++;
        end
        if (k == 64) begin
            n_tests++; n_fail++;
            $display("FAIL wait_cnt: counter %0d never reached %0d", m_cnt, c);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        int          p, base, exp_hi;
        logic [CNT_W-1:0]  rd_duty [NUM_CH];
        logic [NUM_CH-1:0] r_en, r_pol;

        tbl[0] = '{1, 32'hFFFF_FFFF, 1, 32'h000F_FFFF};
        tbl[1] = '{2, 32'h0000_00FF, 2, 32'h0000_000F};
        tbl[2] = '{3, 32'h0000_00A5, 3, 32'h0000_0005};
        tbl[3] = '{4, 32'h0001_2345, 4, 32'h0001_2345};
        tbl[4] = '{7, 32'hFFF0_0001, 7, 32'h0000_0001};
        tbl[5] = '{8, 32'h0000_1234, 8, 32'h0000_0000};
        tbl[6] = '{31, 32'h0000_FFFF, 31, 32'h0000_0000};
        tbl[7] = '{5, 32'h0000_0000, 4, 32'h0001_2345};
        tbl[8] = '{6, 32'h000A_BCDE, 6, 32'h000A_BCDE};

        // Reset state
        reset_n = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        check("reset o_pwm", 32'(o_pwm), 32'h0);
        check("reset o_wrap", 32'(o_wrap), 32'h0);
        check("reset o_data", o_data, 32'h0);
        for (int a = 0; a < 9; a++) begin
            rd(a, d);
            check("reset read", d, 32'h0);
        end

        // Register write/readback vectors
        for (int v = 0; v < 9; v++) begin
            wr(tbl[v].waddr, tbl[v].wdata);
            rd(tbl[v].raddr, d);
            check("table readback", d, tbl[v].exp);
        end

        // P=10: ch0 3/7, ch1 D=0, ch2 D=12 > P, ch3 disabled with inverted polarity
        wr(0, 32'h0);
        wr(2, 32'h7);
        wr(3, 32'h8);
        wr(1, 32'd10);
        wr(4, 32'd3);
        wr(5, 32'd0);
        wr(6, 32'd12);
        wr(7, 32'd9);
        wr(0, 32'h1);
        for (int per = 0; per < 3; per++) begin
            run_count(10);
            check("ch0 high per period", 32'(cnt_hi[0]), 32'd3);
            check("ch1 duty 0", 32'(cnt_hi[1]), 32'd0);
            check("ch2 duty > P", 32'(cnt_hi[2]), 32'd10);
            check("ch3 idle pol", 32'(cnt_hi[3]), 32'd10);
            check("wraps per period", 32'(cnt_wrap), 32'd1);
        end

        // Mid-period duty write lands at the next boundary
        wait_cnt(4);
        wr(4, 32'd7);
        rd(0, d);
        check("upd_pend set", d, 32'h3);
        run_count(4);
        check("rest of period keeps old duty", 32'(cnt_hi[0]), 32'd0);
        run_count(10);
        check("new duty 7", 32'(cnt_hi[0]), 32'd7);
        rd(0, d);
        check("upd_pend cleared", d, 32'h1);

        // Write at the boundary edge itself applies one period later
        wait_cnt(9);
        wr(4, 32'd5);
        run_count(10);
        check("boundary write deferred", 32'(cnt_hi[0]), 32'd7);
        run_count(10);
        check("boundary write applied", 32'(cnt_hi[0]), 32'd5);

        // Randomized configurations against closed-form high counts
        for (int r = 0; r < 6; r++) begin
            wr(0, 32'h0);
            p = $urandom_range(1, 12);
            r_en = NUM_CH'($urandom_range(0, 15));
            r_pol = NUM_CH'($urandom_range(0, 15));
            wr(1, 32'(p));
            wr(2, 32'(r_en));
            wr(3, 32'(r_pol));
            for (int i = 0; i < NUM_CH; i++) begin
                rd_duty[i] = CNT_W'($urandom_range(0, 14));
                wr(4 + i, 32'(rd_duty[i]));
            end
            wr(0, 32'h1);
            run_count(p);
            for (int i = 0; i < NUM_CH; i++) begin
                base = r_en[i] ? ((int'(rd_duty[i]) < p) ? int'(rd_duty[i]) : p) : 0;
                exp_hi = r_pol[i] ? p - base : base;
                check("random high count", 32'(cnt_hi[i]), 32'(exp_hi));
            end
            check("random wraps", 32'(cnt_wrap), 32'd1);
            wr(4 + int'($urandom_range(0, NUM_CH - 1)), 32'($urandom_range(0, 14)));
            run_count(2 * p + int'($urandom_range(0, 3)));
            rd_chk("random readback", int'($urandom_range(0, 9)));
        end

        // Reset mid-period, then the P=0 stuck state and recovery
        run_count(3);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        check("mid reset o_pwm", 32'(o_pwm), 32'h0);
        check("mid reset o_wrap", 32'(o_wrap), 32'h0);
        check("mid reset o_data", o_data, 32'h0);
        rd(0, d);
        check("mid reset ctrl", d, 32'h0);
        rd(1, d);
        check("mid reset period", d, 32'h0);
        wr(2, 32'hF);
        wr(4, 32'd3);
        wr(0, 32'h1);
        run_count(10);
        check("P=0 ch0 idle", 32'(cnt_hi[0]), 32'd0);
        check("P=0 no wraps", 32'(cnt_wrap), 32'd0);
        wr(1, 32'd4);
        tick();
        run_count(4);
        check("recover ch0", 32'(cnt_hi[0]), 32'd3);
        check("recover wraps", 32'(cnt_wrap), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
